// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } arb_state_t;

  // Width of a counter that must hold 0 .. max_val-1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 2) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  import uart_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]             req_last;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             grant;
  logic                         send_en;
  logic [UART_BYTE_W-1:0]       data_rx;
  logic                         over_tx;
  logic                         busy;
  logic                         timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, over_tx,
    output req_ready, grant, send_en, data_rx, busy, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, over_tx,
    input  req_ready, grant, send_en, data_rx, busy, timeout_err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after last_owner in circular order.
module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_owner,
  output logic [N_REQ-1:0]         pick,
  output logic [$clog2(N_REQ)-1:0] pick_idx
);
  localparam int IDX_W = $clog2(N_REQ);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Scan from last_owner+1 around the ring, keeping the first requester seen.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = IDX_W'((int'(last_owner) + off) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found        = 1'b1;
        pick[w_cand]   = 1'b1;
        pick_idx       = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked sharing of one byte UART transmitter between N_REQ sources,
// with an inter-byte gap and a per-byte completion watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int GAP_W = cnt_width(GAP_CYCLES);

  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX    = {WD_W{1'b1}};
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_MAX   = {GAP_W{1'b1}};
  localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(N_REQ - 1);

  arb_state_t             r_state,      w_state_nx;
  logic [N_REQ-1:0]       r_grant,      w_grant_nx;
  logic [IDX_W-1:0]       r_owner,      w_owner_nx;
  logic [IDX_W-1:0]       r_last_owner, w_last_owner_nx;
  logic [UART_BYTE_W-1:0] r_data,       w_data_nx;
  logic                   r_last_q,     w_last_q_nx;
  logic [WD_W-1:0]        r_wd_cnt,     w_wd_nx;
  logic [GAP_W-1:0]       r_gap_cnt,    w_gap_nx;
  logic                   r_send_en;
  logic                   r_busy;
  logic                   r_timeout_err;
  logic                   w_timeout;
  logic                   w_byte_done;
  logic [N_REQ-1:0]       w_ready;
  logic [N_REQ-1:0]       w_pick;
  logic [IDX_W-1:0]       w_pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_owner (r_last_owner),
    .pick       (w_pick),
    .pick_idx   (w_pick_idx)
  );

  // Next-state, counter and datapath decisions for the arbitration FSM.
  always_comb begin
    w_state_nx      = r_state;
    w_grant_nx      = r_grant;
    w_owner_nx      = r_owner;
    w_last_owner_nx = r_last_owner;
    w_data_nx       = r_data;
    w_last_q_nx     = r_last_q;
    w_wd_nx         = r_wd_cnt;
    w_gap_nx        = r_gap_cnt;
    w_timeout       = 1'b0;
    w_byte_done     = 1'b0;
    w_ready         = '0;

    case (r_state)
      IDLE: begin
        if (|bus.req_valid) begin
          w_grant_nx = w_pick;
          w_owner_nx = w_pick_idx;
          w_state_nx = LOAD;
        end else begin
          w_state_nx = IDLE;
        end
      end
      LOAD: begin
        w_ready = r_grant & bus.req_valid;
        // Owner byte lanes are 8 bits wide, so the lane offset is owner*8.
        if (bus.req_valid[r_owner]) begin
          w_data_nx   = bus.req_data[{r_owner, 3'b000} +: UART_BYTE_W];
          w_last_q_nx = bus.req_last[r_owner];
          w_state_nx  = SEND;
        end else begin
          w_state_nx = LOAD;
        end
      end
      SEND: begin
        w_wd_nx    = '0;
        w_state_nx = WAIT;
      end
      WAIT: begin
        // A completion in the watchdog's final cycle still counts as success.
        if (bus.over_tx) begin
          if (GAP_CYCLES == 0) begin
            w_byte_done = 1'b1;
          end else begin
            w_gap_nx   = '0;
            w_state_nx = GAP;
          end
        end else if (r_wd_cnt == WD_LAST) begin
          w_timeout       = 1'b1;
          w_last_owner_nx = r_owner;
          w_grant_nx      = '0;
          w_state_nx      = IDLE;
        end else if (r_wd_cnt != WD_MAX) begin
          w_wd_nx = r_wd_cnt + 1'b1;
        end else begin
          w_wd_nx = r_wd_cnt;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_byte_done = 1'b1;
        end else if (r_gap_cnt != GAP_MAX) begin
          w_gap_nx = r_gap_cnt + 1'b1;
        end else begin
          w_gap_nx = r_gap_cnt;
        end
      end
      default: begin
        w_grant_nx = '0;
        w_state_nx = IDLE;
      end
    endcase

    if (w_byte_done) begin
      if (r_last_q) begin
        w_last_owner_nx = r_owner;
        w_grant_nx      = '0;
        w_state_nx      = IDLE;
      end else begin
        w_state_nx = LOAD;
      end
    end else begin
      w_byte_done = 1'b0;
    end
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_last_owner  <= OWNER_RST;
      r_data        <= 8'h00;
      r_last_q      <= 1'b0;
      r_wd_cnt      <= '0;
      r_gap_cnt     <= '0;
      r_send_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_grant       <= w_grant_nx;
      r_owner       <= w_owner_nx;
      r_last_owner  <= w_last_owner_nx;
      r_data        <= w_data_nx;
      r_last_q      <= w_last_q_nx;
      r_wd_cnt      <= w_wd_nx;
      r_gap_cnt     <= w_gap_nx;
      r_send_en     <= (w_state_nx == SEND);
      r_busy        <= (w_state_nx != IDLE);
      r_timeout_err <= w_timeout;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.grant       = r_grant;
  assign bus.send_en     = r_send_en;
  assign bus.data_rx     = r_data;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

endmodule
